decode_stage: RTL



---
 rtl/decode_pkg.sv | 64 ++++++
 rtl/instr_decoder.sv | 148 ++++++++++++++
 rtl/decode_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, ALU
// operation and immediate-format enums, and the control bundle that
// travels down the pipeline with each instruction.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Bundle value seen after reset and used as the decoder's starting point.
  localparam ctrl_t CTRL_NOP = '{
    alu_op:      ALU_ADD,
    funct3:      3'b000,
    alu_src_imm: 1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    illegal:     1'b0
  };

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder: splits an instruction word into
// register ids (zeroed when unused), a sign-extended immediate and the
// control bundle consumed by execute.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RID_W = 5
) (
  input  logic [XLEN-1:0]  instr,
  output logic [RID_W-1:0] rs1,
  output logic [RID_W-1:0] rs2,
  output logic [RID_W-1:0] rd,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic [XLEN-1:0]  imm,
  output ctrl_t            ctrl
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7_b5;
  logic [RID_W-1:0]    rd_field;
  logic                writes_rd;
  imm_type_e           imm_type;
  logic signed [XLEN-1:0] imm_s;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign rd_field  = instr[7 +: RID_W];

  // Register-register and register-immediate ALU ops share funct3 decoding;
  // only the register form may select SUB.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                              input logic alt,
                                              input logic allow_sub);
    case (f3)
      3'b000:  return (allow_sub && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch comparisons: equality via subtraction, ordering via set-less-than.
  function automatic alu_op_e alu_for_branch(input logic [2:0] f3);
    case (f3)
      3'b100, 3'b101: return ALU_SLT;
      3'b110, 3'b111: return ALU_SLTU;
      default:        return ALU_SUB;
    endcase
  endfunction

  // Assemble the immediate for the given format, sign-extended from bit 31.
  function automatic logic signed [XLEN-1:0] build_imm(input logic [31:0] ins,
                                                       input imm_type_e t);
    logic signed [31:0] raw;
    case (t)
      IMM_I:   raw = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   raw = {ins[31:12], 12'h000};
      IMM_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: raw = '0;
    endcase
    return XLEN'(raw);
  endfunction

  // Opcode-driven control decode; defaults describe an rs1-reading,
  // immediate-sourced instruction with no side effects.
  always_comb begin
    ctrl             = CTRL_NOP;
    ctrl.funct3      = funct3;
    ctrl.alu_src_imm = 1'b1;
    imm_type         = IMM_NONE;
    rs1_used         = 1'b1;
    rs2_used         = 1'b0;
    writes_rd        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        rs1_used    = 1'b0;
        imm_type    = IMM_U;
        ctrl.alu_op = ALU_PASS_B;
        writes_rd   = 1'b1;
      end
      OPC_AUIPC: begin
        rs1_used  = 1'b0;
        imm_type  = IMM_U;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        rs1_used  = 1'b0;
        imm_type  = IMM_J;
        ctrl.jump = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        imm_type  = IMM_I;
        ctrl.jump = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        rs2_used         = 1'b1;
        imm_type         = IMM_B;
        ctrl.branch      = 1'b1;
        ctrl.alu_src_imm = 1'b0;
        ctrl.alu_op      = alu_for_branch(funct3);
      end
      OPC_LOAD: begin
        imm_type      = IMM_I;
        ctrl.mem_read = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        rs2_used       = 1'b1;
        imm_type       = IMM_S;
        ctrl.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type    = IMM_I;
        ctrl.alu_op = alu_from_funct3(funct3, funct7_b5, 1'b0);
        writes_rd   = 1'b1;
      end
      OPC_OP: begin
        rs2_used         = 1'b1;
        ctrl.alu_src_imm = 1'b0;
        ctrl.alu_op      = alu_from_funct3(funct3, funct7_b5, 1'b1);
        writes_rd        = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    ctrl.reg_write = writes_rd && (rd_field != '0);
  end

  assign imm_s = build_imm(instr[31:0], imm_type);
  assign imm   = imm_s;
  assign rd    = writes_rd ? rd_field : '0;
  assign rs1   = rs1_used ? instr[15 +: RID_W] : '0;
  assign rs2   = rs2_used ? instr[20 +: RID_W] : '0;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: fetch handshake, register-file read ids,
// load-use hazard bubble, flush handling and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  localparam int RID_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  output logic [RID_W-1:0] rf_read1_id,
  output logic [RID_W-1:0] rf_read2_id,
  input  logic [XLEN-1:0]  rf_read1_data,
  input  logic [XLEN-1:0]  rf_read2_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RID_W-1:0] ex_rs1_id,
  output logic [RID_W-1:0] ex_rs2_id,
  output logic [RID_W-1:0] ex_rd,
  output ctrl_t            ex_ctrl
);

  logic [RID_W-1:0] dec_rs1;
  logic [RID_W-1:0] dec_rs2;
  logic [RID_W-1:0] dec_rd;
  logic             dec_rs1_used;
  logic             dec_rs2_used;
  logic [XLEN-1:0]  dec_imm;
  ctrl_t            dec_ctrl;

  logic             advance;
  logic             hazard;
  logic             transfer;

  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [XLEN-1:0]  rs1_data_p1;
  logic [XLEN-1:0]  rs2_data_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [RID_W-1:0] rs1_id_p1;
  logic [RID_W-1:0] rs2_id_p1;
  logic [RID_W-1:0] rd_p1;
  ctrl_t            ctrl_p1;

  instr_decoder #(
    .XLEN  (XLEN),
    .RID_W (RID_W)
  ) u_decoder (
    .instr    (if_instr),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .imm      (dec_imm),
    .ctrl     (dec_ctrl)
  );

  // Register file is read straight from the raw fields so data arrives in
  // time to be captured together with the decoded instruction.
  assign rf_read1_id = if_instr[15 +: RID_W];
  assign rf_read2_id = if_instr[20 +: RID_W];

  // A load sitting in ID/EX cannot forward to the instruction behind it, so
  // a consumer of its destination waits one cycle. Unused ids are zero and
  // the destination is nonzero, so they never match.
  assign advance  = !vld_p1 || ex_ready;
  assign hazard   = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) &&
                    ((dec_rs1_used && (dec_rs1 == rd_p1)) ||
                     (dec_rs2_used && (dec_rs2 == rd_p1)));
  assign id_ready = advance && !hazard && !flush;
  assign transfer = if_valid && id_ready;

  // ---- ID -> EX boundary ----
  // ID/EX register: flush kills, an empty advance slot becomes a bubble,
  // a transfer loads everything, otherwise contents hold for backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_id_p1   <= '0;
      rs2_id_p1   <= '0;
      rd_p1       <= '0;
      ctrl_p1     <= CTRL_NOP;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      if (transfer) begin
        vld_p1      <= 1'b1;
        pc_p1       <= if_pc;
        rs1_data_p1 <= rf_read1_data;
        rs2_data_p1 <= rf_read2_data;
        imm_p1      <= dec_imm;
        rs1_id_p1   <= dec_rs1;
        rs2_id_p1   <= dec_rs2;
        rd_p1       <= dec_rd;
        ctrl_p1     <= dec_ctrl;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_pc       = pc_p1;
  assign ex_rs1_data = rs1_data_p1;
  assign ex_rs2_data = rs2_data_p1;
  assign ex_imm      = imm_p1;
  assign ex_rs1_id   = rs1_id_p1;
  assign ex_rs2_id   = rs2_id_p1;
  assign ex_rd       = rd_p1;
  assign ex_ctrl     = ctrl_p1;

endmodule
